// File: rtl/adder_axi_pkg.sv
// Shared definitions for the adder AXI4-Lite master.
// Register map, response codes and FSM state encoding.
package adder_axi_pkg;

    localparam logic [7:0] REG_A     = 8'h00;
    localparam logic [7:0] REG_B     = 8'h04;
    localparam logic [7:0] REG_SUM   = 8'h08;
    localparam logic [7:0] REG_CARRY = 8'h0C;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        WR_A,
        WR_A_B,
        WR_B,
        WR_B_B,
        RD_S,
        RD_S_R,
        RD_C,
        RD_C_R,
        DONE
    } state_t;

endpackage

// File: rtl/adder_axi_if.sv
// AXI4-Lite channel bundle between the adder master and the adder slave.
// The master modport drives requests; the slave modport drives responses.
interface adder_axi_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    import adder_axi_pkg::*;

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/adder_axi_master.sv
// AXI4-Lite master: writes A and B, reads sum and carry, returns result.
// Optional per-phase watchdog enabled by ADDER_MASTER_TIMEOUT_EN.
module adder_axi_master
    import adder_axi_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic                  m1_axi_aclk,
    input  logic                  m1_axi_areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_sum,
    output logic                  rsp_carry,
    output logic                  rsp_err,
    adder_axi_if.master           m1_axi
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t state, state_adv, state_n;
    logic aw_done, w_done;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic aw_fire, w_fire, b_fire, ar_fire, r_fire, cmd_fire;
    logic timeout;

    assign aw_fire  = m1_axi.awvalid && m1_axi.awready;
    assign w_fire   = m1_axi.wvalid && m1_axi.wready;
    assign b_fire   = m1_axi.bvalid && m1_axi.bready;
    assign ar_fire  = m1_axi.arvalid && m1_axi.arready;
    assign r_fire   = m1_axi.rvalid && m1_axi.rready;
    assign cmd_fire = cmd_valid && cmd_ready;
    assign m1_axi.wstrb = '1;

    always_comb begin
        cmd_ready      = (state == IDLE);
        rsp_valid      = (state == DONE);
        m1_axi.awvalid = 1'b0;
        m1_axi.wvalid  = 1'b0;
        m1_axi.awaddr  = '0;
        m1_axi.wdata   = '0;
        m1_axi.bready  = 1'b0;
        m1_axi.arvalid = 1'b0;
        m1_axi.araddr  = '0;
        m1_axi.rready  = 1'b0;
        unique case (state)
            WR_A: begin
                m1_axi.awvalid = !aw_done;
                m1_axi.wvalid  = !w_done;
                m1_axi.awaddr  = BASE_ADDR + ADDR_WIDTH'(REG_A);
                m1_axi.wdata   = a_q;
            end
            WR_B: begin
                m1_axi.awvalid = !aw_done;
                m1_axi.wvalid  = !w_done;
                m1_axi.awaddr  = BASE_ADDR + ADDR_WIDTH'(REG_B);
                m1_axi.wdata   = b_q;
            end
            WR_A_B, WR_B_B: m1_axi.bready = 1'b1;
            RD_S: begin
                m1_axi.arvalid = 1'b1;
                m1_axi.araddr  = BASE_ADDR + ADDR_WIDTH'(REG_SUM);
            end
            RD_C: begin
                m1_axi.arvalid = 1'b1;
                m1_axi.araddr  = BASE_ADDR + ADDR_WIDTH'(REG_CARRY);
            end
            RD_S_R, RD_C_R: m1_axi.rready = 1'b1;
            default: ;
        endcase
    end

    // A write phase ends once both channels have handshaken, in any order.
    always_comb begin
        state_adv = state;
        unique case (state)
            IDLE:   if (cmd_fire) state_adv = WR_A;
            WR_A:   if ((aw_done || aw_fire) && (w_done || w_fire)) state_adv = WR_A_B;
            WR_A_B: if (b_fire) state_adv = WR_B;
            WR_B:   if ((aw_done || aw_fire) && (w_done || w_fire)) state_adv = WR_B_B;
            WR_B_B: if (b_fire) state_adv = RD_S;
            RD_S:   if (ar_fire) state_adv = RD_S_R;
            RD_S_R: if (r_fire) state_adv = RD_C;
            RD_C:   if (ar_fire) state_adv = RD_C_R;
            RD_C_R: if (r_fire) state_adv = DONE;
            DONE:   if (rsp_ready) state_adv = IDLE;
            default: state_adv = IDLE;
        endcase
        state_n = timeout ? DONE : state_adv;
    end

`ifdef ADDER_MASTER_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] cnt;
    logic waiting;

    assign waiting = (state != IDLE) && (state != DONE) && (state_adv == state);
    assign timeout = waiting && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
        if (m1_axi_areset)          cnt <= '0;
        else if (state_n != state)  cnt <= '0;
        else if (waiting)           cnt <= cnt + CW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
        if (m1_axi_areset) begin
            state     <= IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n != state) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_fire) aw_done <= 1'b1;
                if (w_fire)  w_done  <= 1'b1;
            end
            if (cmd_fire) begin
                a_q       <= cmd_a;
                b_q       <= cmd_b;
                rsp_sum   <= '0;
                rsp_carry <= 1'b0;
                rsp_err   <= 1'b0;
            end
            if (b_fire && m1_axi.bresp != OKAY) rsp_err <= 1'b1;
            if (r_fire) begin
                if (m1_axi.rresp != OKAY) rsp_err <= 1'b1;
                if (state == RD_S_R) rsp_sum   <= m1_axi.rdata;
                else                 rsp_carry <= m1_axi.rdata[0];
            end
            if (timeout) rsp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_axi_master.sv
// Testbench for adder_axi_master with a behavioural adder slave.
// Covers latency, write ordering, carry, error responses, backpressure, reset.
module tb_adder_axi_master;

    localparam int DW = 32;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    logic cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_carry, rsp_err;
    logic [DW-1:0] cmd_a, cmd_b, rsp_sum;

    always #5 clk = ~clk;

    adder_axi_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

    adder_axi_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .BASE_ADDR(8'h00), .TIMEOUT_CYCLES(16)
    ) dut (
        .m1_axi_aclk(clk), .m1_axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .m1_axi(axi)
    );

    int errors = 0;
    int checks = 0;

    // Slave model state
    int unsigned aw_delay = 0, aw_seen = 0;
    bit ar_block = 0, b_err_on_b = 0;
    logic [DW-1:0] reg_a = '0, reg_b = '0;
    bit got_aw, got_w, b_pend, r_pend, aw_hold;
    logic [AW-1:0] aw_addr_q, aw_last;
    logic [DW-1:0] w_data_q, r_data;
    logic [1:0] b_code;
    int unsigned stab_viol = 0, strb_bad = 0, w_first = 0;
    int log_addr[$];
    bit log_wr[$];
    logic [DW-1:0] log_data[$];

    function automatic logic [DW:0] ref_add(input logic [DW-1:0] a, b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Slave drives and samples at negedge; handshakes land on the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
            aw_hold = 0; aw_seen = 0;
            axi.awready = 0; axi.wready = 0; axi.arready = 0;
            axi.bvalid = 0; axi.bresp = 0;
            axi.rvalid = 0; axi.rresp = 0; axi.rdata = '0;
        end else begin
            axi.bvalid = b_pend;
            axi.bresp  = b_pend ? b_code : 2'b00;
            axi.rvalid = r_pend;
            axi.rdata  = r_pend ? r_data : '0;
            axi.rresp  = 2'b00;
            if (axi.awvalid) begin
                aw_seen++;
                if (aw_hold && axi.awaddr !== aw_last) stab_viol++;
            end else begin
                aw_seen = 0;
            end
            axi.awready = axi.awvalid && (aw_seen > aw_delay);
            axi.wready  = 1'b1;
            axi.arready = !ar_block;
            if (axi.awvalid && !axi.wvalid) w_first++;
            if (axi.bvalid && axi.bready) b_pend = 0;
            if (axi.rvalid && axi.rready) r_pend = 0;
            if (axi.awvalid && axi.awready) begin
                got_aw = 1; aw_addr_q = axi.awaddr; aw_hold = 0;
            end else if (axi.awvalid) begin
                aw_hold = 1; aw_last = axi.awaddr;
            end else begin
                aw_hold = 0;
            end
            if (axi.wvalid && axi.wready) begin
                got_w = 1; w_data_q = axi.wdata;
                if (axi.wstrb !== 4'hF) strb_bad++;
            end
            if (got_aw && got_w) begin
                got_aw = 0; got_w = 0;
                log_addr.push_back(int'(aw_addr_q));
                log_wr.push_back(1'b1);
                log_data.push_back(w_data_q);
                if (aw_addr_q == 8'h00) reg_a = w_data_q;
                else if (aw_addr_q == 8'h04) reg_b = w_data_q;
                b_pend = 1;
                b_code = (b_err_on_b && aw_addr_q == 8'h04) ? 2'b10 : 2'b00;
            end
            if (axi.arvalid && axi.arready) begin
                logic [DW:0] s;
                s = {1'b0, reg_a} + {1'b0, reg_b};
                log_addr.push_back(int'(axi.araddr));
                log_wr.push_back(1'b0);
                log_data.push_back('0);
                if (axi.araddr == 8'h08)      r_data = s[DW-1:0];
                else if (axi.araddr == 8'h0C) r_data = {{(DW-1){1'b0}}, s[DW]};
                else                          r_data = '0;
                r_pend = 1;
            end
        end
    end

    task automatic clear_log();
        log_addr.delete(); log_wr.delete(); log_data.delete();
    endtask

    task automatic run_cmd(input logic [DW-1:0] a, b, input bit consume,
                           output logic [DW-1:0] s, output logic c, e,
                           output int lat);
        int n;
        bit ok;
        ok = 1;
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) ok = 0;
        @(negedge clk);
        cmd_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        if (!rsp_valid) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL run_cmd_bound: cmd_ready=%b rsp_valid=%b required both seen", cmd_ready, rsp_valid);
        end
        s = rsp_sum; c = rsp_carry; e = rsp_err;
        if (consume) begin
            rsp_ready = 1; @(negedge clk); rsp_ready = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++;
        if ({rsp_valid, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 6'b0) begin
            errors++; $display("FAIL reset_valids: got %b want 000000",
                {rsp_valid, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready});
        end
        checks++;
        if ({rsp_sum, rsp_carry, rsp_err} !== '0 || axi.awaddr !== '0 || axi.wdata !== '0) begin
            errors++; $display("FAIL reset_data: sum=%h c=%b e=%b awaddr=%h want zeros", rsp_sum, rsp_carry, rsp_err, axi.awaddr);
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release: cmd_ready=%b want 1", cmd_ready); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] s, a, b;
        logic c, e;
        logic [DW:0] r;
        int lat;
        int ea[4];
        a = 32'h0000AABB; b = 32'h0000CCDD;
        ea = '{0, 4, 8, 12};
        clear_log();
        strb_bad = 0;
        run_cmd(a, b, 1, s, c, e, lat);
        r = ref_add(a, b);
        checks++;
        if (s !== r[DW-1:0] || s !== 32'h00017798) begin errors++; $display("FAIL basic_sum: got %h want %h", s, r[DW-1:0]); end
        checks++;
        if (c !== r[DW] || e !== 1'b0) begin errors++; $display("FAIL basic_flags: carry=%b err=%b want %b 0", c, e, r[DW]); end
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d want 9", lat); end
        checks++;
        if (strb_bad !== 0) begin errors++; $display("FAIL basic_wstrb: %0d bad strobes want 0", strb_bad); end
        checks++;
        if (log_addr.size() !== 4) begin
            errors++; $display("FAIL basic_txn_count: got %0d want 4", log_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic [DW-1:0] ed;
                ed = (i == 0) ? a : (i == 1) ? b : '0;
                checks++;
                if (log_addr[i] !== ea[i] || log_wr[i] !== (i < 2) || log_data[i] !== ed) begin
                    errors++;
                    $display("FAIL basic_txn%0d: addr=%h wr=%b data=%h want addr=%h wr=%b data=%h",
                        i, log_addr[i], log_wr[i], log_data[i], ea[i], (i < 2), ed);
                end
            end
        end
    endtask

    task automatic test_aw_delay();
        logic [DW-1:0] s;
        logic c, e;
        logic [DW:0] r;
        int lat;
        aw_delay = 3; stab_viol = 0; w_first = 0;
        run_cmd(32'h0000AABB, 32'h0000CCDD, 1, s, c, e, lat);
        aw_delay = 0;
        r = ref_add(32'h0000AABB, 32'h0000CCDD);
        checks++;
        if ({c, s, e} !== {r, 1'b0}) begin errors++; $display("FAIL awdelay_result: got %b_%h_%b want %b_%h_0", c, s, e, r[DW], r[DW-1:0]); end
        checks++;
        if (w_first !== 6) begin errors++; $display("FAIL awdelay_w_first: awvalid-only cycles=%0d want 6", w_first); end
        checks++;
        if (stab_viol !== 0) begin errors++; $display("FAIL awdelay_stable: addr changes=%0d want 0", stab_viol); end
    endtask

    task automatic test_carry();
        logic [DW-1:0] s;
        logic c, e;
        int lat;
        run_cmd(32'hFFFFFFFF, 32'h00000001, 1, s, c, e, lat);
        checks++;
        if (s !== 32'h0 || c !== 1'b1 || e !== 1'b0) begin
            errors++; $display("FAIL carry: sum=%h c=%b e=%b want 00000000 1 0", s, c, e);
        end
    endtask

    task automatic test_bresp_err();
        logic [DW-1:0] s, a, b;
        logic c, e;
        logic [DW:0] r;
        int lat;
        a = 32'h12345678; b = 32'h11111111;
        clear_log();
        b_err_on_b = 1;
        run_cmd(a, b, 1, s, c, e, lat);
        b_err_on_b = 0;
        r = ref_add(a, b);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL bresp_err_flag: got %b want 1", e); end
        checks++;
        if (log_addr.size() !== 4 || s !== r[DW-1:0]) begin
            errors++; $display("FAIL bresp_err_seq: txns=%0d sum=%h want 4 %h", log_addr.size(), s, r[DW-1:0]);
        end
        a = $urandom; b = $urandom;
        run_cmd(a, b, 1, s, c, e, lat);
        r = ref_add(a, b);
        checks++;
        if ({c, s, e} !== {r, 1'b0}) begin errors++; $display("FAIL bresp_recover: got %b_%h_%b want %b_%h_0", c, s, e, r[DW], r[DW-1:0]); end
    endtask

    task automatic test_random();
        logic [DW-1:0] s, a, b;
        logic c, e;
        logic [DW:0] r;
        int lat;
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom;
            if (i == 0) b = ~a;
            aw_delay = $urandom_range(0, 3);
            run_cmd(a, b, 1, s, c, e, lat);
            r = ref_add(a, b);
            checks++;
            if ({c, s, e} !== {r, 1'b0}) begin
                errors++; $display("FAIL random%0d: a=%h b=%h got %b_%h_%b want %b_%h_0", i, a, b, c, s, e, r[DW], r[DW-1:0]);
            end
        end
        aw_delay = 0;
    endtask

    task automatic test_hold_and_reset();
        logic [DW-1:0] s;
        logic c, e;
        logic [DW:0] r;
        int lat, bad, n;
        run_cmd(32'h0BADF00D, 32'h10000001, 0, s, c, e, lat);
        r = ref_add(32'h0BADF00D, 32'h10000001);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_sum !== r[DW-1:0] || rsp_carry !== r[DW]
                || rsp_err !== 1'b0 || cmd_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL hold_stable: %0d unstable cycles want 0 (sum=%h)", bad, rsp_sum); end
        rsp_ready = 1; @(negedge clk); rsp_ready = 0;
        cmd_a = 32'h1; cmd_b = 32'h2; cmd_valid = 1;
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!(axi.awvalid && axi.awaddr == 8'h04) && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!(axi.awvalid && axi.awaddr == 8'h04)) begin
            errors++; $display("FAIL reach_wr_b: awvalid=%b awaddr=%h want 1 04", axi.awvalid, axi.awaddr);
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rsp_valid} !== 6'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_valids: valids=%b cmd_ready=%b want 000000 1",
                {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rsp_valid}, cmd_ready);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midreset_release: cmd_ready=%b want 1", cmd_ready); end
    endtask

`ifdef ADDER_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int ar_cnt, n;
        ar_block = 1;
        @(negedge clk);
        cmd_a = 32'h5; cmd_b = 32'h6; cmd_valid = 1;
        @(negedge clk);
        cmd_valid = 0;
        ar_cnt = 0; n = 0;
        while (!rsp_valid && n < 200) begin
            if (axi.arvalid) ar_cnt++;
            @(negedge clk); n++;
        end
        checks++;
        if (ar_cnt !== 16) begin errors++; $display("FAIL timeout_cycles: arvalid cycles=%0d want 16", ar_cnt); end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || axi.arvalid !== 1'b0 || rsp_sum !== '0) begin
            errors++; $display("FAIL timeout_rsp: valid=%b err=%b arvalid=%b sum=%h want 1 1 0 0",
                rsp_valid, rsp_err, axi.arvalid, rsp_sum);
        end
        rsp_ready = 1; @(negedge clk); rsp_ready = 0;
        ar_block = 0;
    endtask
`endif

    initial begin
        rst = 1; cmd_valid = 0; rsp_ready = 0; cmd_a = '0; cmd_b = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_aw_delay();
        test_carry();
        test_bresp_err();
        test_random();
        test_hold_and_reset();
`ifdef ADDER_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
